// File: rtl/dzcpu_ucode_pkg.sv
// Shared microcode encoding for the dzcpu sequencer, microcode ROM and flow LUTs.
// Uop layout: flow [12:9], op [8:4], operand [3:0].
package dzcpu_ucode_pkg;

  localparam int FLOW_HI = 12;
  localparam int FLOW_LO = 9;
  localparam int OPER_HI = 8;
  localparam int OPER_LO = 4;
  localparam int OPND_HI = 3;
  localparam int OPND_LO = 0;

  typedef enum logic [3:0] {
    F_OP         = 4'd0,
    F_INC        = 4'd1,
    F_EOF        = 4'd2,
    F_INC_EOF    = 4'd3,
    F_EOF_FU     = 4'd4,
    F_INC_EOF_FU = 4'd5,
    F_INC_EOF_Z  = 4'd6,
    F_INC_EOF_NZ = 4'd7,
    F_NOP        = 4'd8
  } flow_e;

  localparam logic [4:0] UOP_NOP = 5'h00;
  localparam logic [4:0] UOP_ADD = 5'h01;
  localparam logic [4:0] UOP_SUB = 5'h02;
  localparam logic [4:0] UOP_LD  = 5'h03;
  localparam logic [4:0] UOP_ST  = 5'h04;
  localparam logic [4:0] UOP_JCB = 5'h1f;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_e;

endpackage

// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: owns the uPC, decodes each uop's flow field into
// datapath strobes, handles the CB-prefix redirect, stalls and runaway detection.
module dzcpu_useq
  import dzcpu_ucode_pkg::*;
#(
  parameter int UOP_W  = 13,
  parameter int UPC_W  = 8,
  parameter int ICNT_W = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMop,
  input  logic              iMopValid,
  input  logic [UPC_W-1:0]  iUopFlowIdx,
  input  logic [UPC_W-1:0]  iCbUopFlowIdx,
  input  logic [UOP_W-1:0]  iUop,
  input  logic              iFlagZ,
  input  logic              iStall,
  output logic [7:0]        oMop,
  output logic [UPC_W-1:0]  oUopAddr,
  output logic              oFetchReq,
  output logic              oExec,
  output logic              oPcInc,
  output logic              oFlagUpdate,
  output logic              oEof,
  output logic [ICNT_W-1:0] oInsnCount,
  output logic              oUcodeErr
);

  state_e     state;
  flow_e      flow;
  logic       active, jcb, redir, wrap;
  logic       exec, pcinc, fu, eof_f, adv, bad;
  logic       unused_opnd;

  assign flow        = flow_e'(iUop[FLOW_HI:FLOW_LO]);
  assign jcb         = (iUop[OPER_HI:OPER_LO] == UOP_JCB);
  assign active      = (state == S_EXEC) && !iStall;
  assign redir       = active && jcb;
  assign oFetchReq   = (state == S_FETCH);
  assign unused_opnd = ^iUop[OPND_HI:OPND_LO];

  always_comb begin
    exec  = 1'b0;
    pcinc = 1'b0;
    fu    = 1'b0;
    eof_f = 1'b0;
    adv   = 1'b0;
    bad   = 1'b0;
    if (active) begin
      unique case (flow)
        F_OP:         begin exec = 1'b1; adv = 1'b1; end
        F_INC:        begin exec = 1'b1; pcinc = 1'b1; adv = 1'b1; end
        F_EOF:        begin exec = 1'b1; eof_f = 1'b1; end
        F_INC_EOF:    begin exec = 1'b1; pcinc = 1'b1; eof_f = 1'b1; end
        F_EOF_FU:     begin exec = 1'b1; fu = 1'b1; eof_f = 1'b1; end
        F_INC_EOF_FU: begin exec = 1'b1; pcinc = 1'b1; fu = 1'b1; eof_f = 1'b1; end
        // Conditional exit: the exiting uop is a pure PC bump, not executed.
        F_INC_EOF_Z: begin
          pcinc = 1'b1;
          if (iFlagZ) eof_f = 1'b1;
          else begin exec = 1'b1; adv = 1'b1; end
        end
        F_INC_EOF_NZ: begin
          pcinc = 1'b1;
          if (!iFlagZ) eof_f = 1'b1;
          else begin exec = 1'b1; adv = 1'b1; end
        end
        F_NOP:        adv = 1'b1;
        default:      begin exec = 1'b1; eof_f = 1'b1; bad = 1'b1; end
      endcase
    end
  end

  // A CB redirect suppresses execution and end-of-flow; the PC bump survives.
  assign wrap        = adv && !jcb && (oUopAddr == {UPC_W{1'b1}});
  assign oExec       = exec && !jcb;
  assign oPcInc      = pcinc;
  assign oFlagUpdate = fu && !jcb;
  assign oEof        = (eof_f && !jcb) || wrap;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state      <= S_FETCH;
      oUopAddr   <= '0;
      oMop       <= '0;
      oInsnCount <= '0;
      oUcodeErr  <= 1'b0;
    end else if (!iStall) begin
      unique case (state)
        S_FETCH: if (iMopValid) begin
          oMop  <= iMop;
          state <= S_DECODE;
        end
        S_DECODE: begin
          oUopAddr <= iUopFlowIdx;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (redir)     oUopAddr <= iCbUopFlowIdx;
          else if (oEof) state    <= S_FETCH;
          else if (adv)  oUopAddr <= oUopAddr + 1'b1;
          if (bad || wrap) oUcodeErr <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
      oInsnCount <= oInsnCount + ICNT_W'(oEof);
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq with a small ROM model driven from the uPC.
module tb_dzcpu_useq;
  import dzcpu_ucode_pkg::*;

  logic        iClock, iReset;
  logic [7:0]  iMop;
  logic        iMopValid;
  logic [7:0]  iUopFlowIdx, iCbUopFlowIdx;
  logic [12:0] iUop;
  logic        iFlagZ, iStall;
  logic [7:0]  oMop, oUopAddr;
  logic        oFetchReq, oExec, oPcInc, oFlagUpdate, oEof;
  logic [15:0] oInsnCount;
  logic        oUcodeErr;

  logic [12:0] rom [256];
  int tests = 0;
  int fails = 0;
  int npc, nex, neof;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
    .iUopFlowIdx(iUopFlowIdx), .iCbUopFlowIdx(iCbUopFlowIdx), .iUop(iUop),
    .iFlagZ(iFlagZ), .iStall(iStall), .oMop(oMop), .oUopAddr(oUopAddr),
    .oFetchReq(oFetchReq), .oExec(oExec), .oPcInc(oPcInc),
    .oFlagUpdate(oFlagUpdate), .oEof(oEof), .oInsnCount(oInsnCount),
    .oUcodeErr(oUcodeErr)
  );

  assign iUop = rom[oUopAddr];
  wire [3:0] stb = {oExec, oPcInc, oFlagUpdate, oEof};

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  function automatic logic [12:0] u(input logic [3:0] f, input logic [4:0] op);
    return {f, op, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1ns after the falling edge.
  task automatic cyc();
    @(negedge iClock);
    #1;
  endtask

  // From FETCH, present an opcode and walk through DECODE into EXEC at idx.
  task automatic start(input logic [7:0] mop, input logic [7:0] idx);
    iMop = mop; iMopValid = 1'b1; iUopFlowIdx = idx;
    #1;
    chk("fetchreq", oFetchReq, 1);
    chk("fetch_stb", stb, 4'b0000);
    cyc();
    iMopValid = 1'b0;
    chk("decode_fetchreq", oFetchReq, 0);
    chk("decode_mop", oMop, mop);
    chk("decode_stb", stb, 4'b0000);
    cyc();
    chk("exec_upc", oUopAddr, idx);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = u(F_EOF, UOP_NOP);
    rom[0]   = u(F_INC_EOF, UOP_ADD);
    rom[5]   = u(F_INC, UOP_LD);
    rom[6]   = u(F_INC, UOP_LD);
    rom[7]   = u(F_OP,  UOP_ADD);
    rom[8]   = u(F_INC_EOF, UOP_ST);
    rom[13]  = u(F_OP, UOP_NOP);
    rom[14]  = u(F_OP, UOP_NOP);
    rom[15]  = u(F_OP, UOP_JCB);
    rom[16]  = u(F_EOF_FU, UOP_SUB);
    rom[17]  = u(F_OP, UOP_LD);
    rom[18]  = u(F_OP, UOP_LD);
    rom[19]  = u(F_INC_EOF_Z, UOP_NOP);
    rom[20]  = u(F_OP, UOP_ADD);
    rom[21]  = u(F_OP, UOP_ADD);
    rom[22]  = u(F_EOF, UOP_ST);
    for (int i = 50; i < 61; i++) rom[i] = u(F_INC, UOP_LD);
    rom[61]  = u(F_EOF, UOP_ST);
    rom[255] = u(F_OP, UOP_ADD);

    iReset = 1'b0; iMop = 8'h00; iMopValid = 1'b0; iUopFlowIdx = 8'h00;
    iCbUopFlowIdx = 8'h00; iFlagZ = 1'b0; iStall = 1'b0;
    #12;
    chk("rst_upc", oUopAddr, 0);
    chk("rst_mop", oMop, 0);
    chk("rst_cnt", oInsnCount, 0);
    chk("rst_err", oUcodeErr, 0);
    chk("rst_stb", stb, 4'b0000);
    chk("rst_fetchreq", oFetchReq, 1);
    cyc();
    iReset = 1'b1;
    cyc();

    // One-uop instruction: 3 cycles
    start(8'h00, 8'd0);
    chk("t1_stb", stb, 4'b1101);
    cyc();
    chk("t1_cnt", oInsnCount, 1);
    chk("t1_fetch", oFetchReq, 1);

    // Four-uop flow at 5
    start(8'h3c, 8'd5);
    npc = 0; nex = 0; neof = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_upc", oUopAddr, 5 + i);
      npc += oPcInc; nex += oExec; neof += oEof;
      cyc();
    end
    chk("t2_npc", npc, 3);
    chk("t2_nex", nex, 4);
    chk("t2_neof", neof, 1);
    chk("t2_cnt", oInsnCount, 2);

    // Conditional exit, Z=1
    iFlagZ = 1'b1;
    start(8'h20, 8'd17);
    cyc(); cyc();
    chk("t3z_upc", oUopAddr, 19);
    chk("t3z_stb", stb, 4'b0101);
    cyc();
    chk("t3z_fetch", oFetchReq, 1);
    chk("t3z_cnt", oInsnCount, 3);

    // Conditional fall-through, Z=0
    iFlagZ = 1'b0;
    start(8'h20, 8'd17);
    cyc(); cyc();
    chk("t3n_stb19", stb, 4'b1100);
    cyc();
    chk("t3n_stb20", stb, 4'b1000);
    cyc(); cyc();
    chk("t3n_upc22", oUopAddr, 22);
    chk("t3n_stb22", stb, 4'b1001);
    cyc();
    chk("t3n_cnt", oInsnCount, 4);

    // CB redirect 15 -> 16 without a DECODE cycle
    iCbUopFlowIdx = 8'd16;
    start(8'hcb, 8'd13);
    cyc(); cyc();
    chk("t4_upc15", oUopAddr, 15);
    chk("t4_jcb_stb", stb, 4'b0000);
    cyc();
    chk("t4_upc16", oUopAddr, 16);
    chk("t4_fetchreq", oFetchReq, 0);
    chk("t4_stb16", stb, 4'b1011);
    cyc();
    chk("t4_cnt", oInsnCount, 5);

    // Stall at 52 for 3 cycles, then async reset at 54
    start(8'h11, 8'd50);
    cyc(); cyc();
    iStall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_upc", oUopAddr, 52);
      chk("t5_stall_stb", stb, 4'b0000);
      cyc();
    end
    iStall = 1'b0;
    #1;
    chk("t5_resume_upc", oUopAddr, 52);
    chk("t5_resume_stb", stb, 4'b1100);
    cyc(); cyc();
    chk("t5_upc54", oUopAddr, 54);
    #2 iReset = 1'b0;
    #1;
    chk("t5_areset_upc", oUopAddr, 0);
    chk("t5_areset_fetch", oFetchReq, 1);
    chk("t5_areset_stb", stb, 4'b0000);
    chk("t5_areset_cnt", oInsnCount, 0);
    cyc();
    iReset = 1'b1;
    cyc();

    // Runaway at 255
    start(8'hff, 8'd255);
    chk("t6_stb", stb, 4'b1001);
    chk("t6_err_pre", oUcodeErr, 0);
    cyc();
    chk("t6_err", oUcodeErr, 1);
    chk("t6_fetch", oFetchReq, 1);
    chk("t6_cnt", oInsnCount, 1);
    start(8'h00, 8'd0);
    chk("t6_next_stb", stb, 4'b1101);
    cyc();
    chk("t6_err_sticky", oUcodeErr, 1);
    chk("t6_cnt2", oInsnCount, 2);
    iReset = 1'b0;
    #1;
    chk("t6_err_clr", oUcodeErr, 0);
    cyc();
    iReset = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
Micro-sequencer for the dzcpu core. It sits directly downstream of the opcode flow-index LUTs and the microcode ROM. It holds the micro-program counter (uPC) that addresses the ROM and decodes each uop's flow field into PC-increment, execute, flag-update and end-of-flow strobes for the datapath. It also handles the 0xCB prefix redirect, Z-conditional early exit, memory stalls, a retired-instruction counter and a sticky microcode-runaway error.

Parameters:
UOP_W, 13, microcode word width
UPC_W, 8, uPC / flow-index width
ICNT_W, 16, retired-instruction counter width

Ports:
iClock  in  1  core clock
iReset  in  1  asynchronous, active-low reset
iMop  in  8  opcode byte from memory bus
iMopValid  in  1  iMop is valid this cycle
iUopFlowIdx  in  UPC_W  main LUT output for the latched opcode
iCbUopFlowIdx  in  UPC_W  CB LUT output for the current memory byte
iUop  in  UOP_W  ROM word at oUopAddr
iFlagZ  in  1  current Z flag
iStall  in  1  memory wait; freezes the sequencer
oMop  out  8  latched opcode, feeds the main LUT
oUopAddr  out  UPC_W  uPC, feeds the ROM address
oFetchReq  out  1  high in FETCH state
oExec  out  1  datapath executes the op/operand fields of iUop this cycle
oPcInc  out  1  increment architectural PC
oFlagUpdate  out  1  commit ALU flags
oEof  out  1  last uop of the instruction
oInsnCount  out  ICNT_W  retired instructions
oUcodeErr  out  1  sticky runaway flag

Behaviour:
- Reset (async on iReset low): state FETCH, uPC 0, oMop 0, oInsnCount 0, oUcodeErr 0. All strobes (oExec, oPcInc, oFlagUpdate, oEof) are 0.
- Strobes are combinational from state, iUop, iFlagZ and iStall. iStall=1 forces every strobe to 0 and freezes all registers.
- FETCH: oFetchReq=1. On iMopValid & !iStall: latch oMop<=iMop and go to DECODE. No uop is executed in FETCH.
- DECODE (1 cycle): uPC<=iUopFlowIdx, go to EXEC.
- EXEC: flow field iUop[12:9] is decoded per cycle when !iStall. Codes:
  - OP (0): oExec; uPC+1.
  - INC (1): oExec, oPcInc; uPC+1.
  - EOF (2): oExec, oEof; go to FETCH.
  - INC_EOF (3): oExec, oPcInc, oEof; go to FETCH.
  - EOF_FU (4): oExec, oFlagUpdate, oEof; go to FETCH.
  - INC_EOF_FU (5): oExec, oPcInc, oFlagUpdate, oEof; go to FETCH.
  - INC_EOF_Z (6): oPcInc always. If iFlagZ=1: oExec=0, oEof=1, go to FETCH. Else: oExec=1, uPC+1.
  - INC_EOF_NZ (7): same as INC_EOF_Z with the condition inverted.
  - NOP (8): no exec; uPC+1.
  - Codes 9-15: treated as EOF and set oUcodeErr.
- JCB: when the op field iUop[8:4] equals UOP_JCB, oExec=0. The flow field's oPcInc still applies. uPC<=iCbUopFlowIdx next cycle and the state stays EXEC (no DECODE cycle). JCB combined with an EOF-class flow: the redirect wins and oEof=0.
- oInsnCount increments by 1 on every cycle where oEof=1. It wraps to 0 at its maximum value.
- Runaway: a uPC+1 that would wrap from 2^UPC_W-1 to 0 sets oUcodeErr, forces oEof and returns to FETCH. oUcodeErr clears only on reset.
- Reset mid-flow: the sequencer returns immediately to FETCH with uPC 0. No partial strobes are emitted after reset asserts.
- Throughput: a one-uop instruction takes FETCH + DECODE + 1 EXEC = 3 cycles minimum. Stall cycles add 1:1.

Decomposition:
- Shared package dzcpu_ucode_pkg holds:
  - flow-code enum (OP..INC_EOF_NZ) and op-code constants including UOP_JCB;
  - field bounds: FLOW [12:9], OPER [8:4], OPND [3:0];
  - sequencer state enum {FETCH, DECODE, EXEC}.
- The ROM and LUTs import the same package.
- No sub-module. The flow decoder is a single combinational block inside dzcpu_useq.

Test Plan:
- Reset then iMop=0x00 valid, iUopFlowIdx=0, ROM[0]=INC_EOF: oFetchReq, then DECODE, then oExec+oPcInc+oEof in cycle 3. oInsnCount=1.
- 4-uop flow at index 5 (INC, INC, OP, INC_EOF): oPcInc pulses 3, oExec 4, single oEof. oUopAddr sequence 5,6,7,8.
- Conditional at index 17 (INC_EOF_Z at 19), iFlagZ=1: oEof at uPC=19 with oExec=0. Repeat with iFlagZ=0: uPC advances through 22, oEof at 22.
- CB: flow at 13 with JCB at 15, iCbUopFlowIdx=16, ROM[16]=EOF_FU: uPC goes 15 to 16 directly. oFlagUpdate+oEof at 16.
- iStall held 3 cycles mid-flow at uPC=52: uPC stays 52, all strobes 0, resumes identically. Async reset asserted at uPC=54: state FETCH, uPC 0 without waiting for a clock edge.
- ROM[255]=OP reached via iUopFlowIdx=255: oUcodeErr=1 and oEof. Error persists across later instructions until reset.
